acl_scfifo_rd_stream: RTL

ACL_SCFIFO_RD_STREAM -- requirements
Module: acl_scfifo_rd_stream

---
 rtl/acl_fifo_pkg.sv | 8 +
 rtl/acl_scfifo_rd_stream.sv | 117 +++++++++++
 2 files changed

// File: rtl/acl_fifo_pkg.sv
// rtl/acl_fifo_pkg.sv - shared constants for the ACL FIFO wrappers
package acl_fifo_pkg;

  localparam int ECC_FATAL_BIT  = 0;
  localparam int ECC_CORR_BIT   = 1;
  localparam int RD_LATENCY_MAX = 2;

endpackage

// File: rtl/acl_scfifo_rd_stream.sv
// rtl/acl_scfifo_rd_stream.sv - credit-based read-side adapter turning a normal-mode scfifo into a ready/valid stream
module acl_scfifo_rd_stream
  import acl_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           aclr,
  input  logic                           sclr,
  input  logic                           fifo_empty,
  input  logic [WIDTH-1:0]               fifo_q,
  input  logic [1:0]                     fifo_ecc_status,
  output logic                           fifo_rdreq,
  output logic                           o_valid,
  output logic [WIDTH-1:0]               o_data,
  input  logic                           i_ready,
  output logic                           o_ecc_fatal,
  output logic                           o_ecc_corrected,
  output logic [$clog2(BUF_DEPTH+1)-1:0] o_occupancy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [RD_LATENCY-1:0] r_inflight;
  logic                  r_ecc_fatal;
  logic                  r_ecc_corrected;
  logic [WIDTH-1:0]      r_buf [BUF_DEPTH];

  logic                  w_pop;
  logic                  w_capture;
  logic [CRD_W-1:0]      w_inflight_cnt;
  logic [CRD_W-1:0]      w_credits;
  logic [CRD_W-1:0]      w_credits_after_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + CRD_W'(r_inflight[i]);
    end
  end

  // Every issued read already owns a buffer slot, so the buffer can never overflow.
  assign w_pop               = o_valid && i_ready;
  assign w_capture           = r_inflight[RD_LATENCY-1];
  assign w_credits           = CRD_W'(r_count) + w_inflight_cnt;
  assign w_credits_after_pop = w_credits - CRD_W'(w_pop);
  assign fifo_rdreq          = !aclr && !sclr && !fifo_empty &&
                               (w_credits_after_pop < CRD_W'(BUF_DEPTH));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_inflight      <= '0;
      r_ecc_fatal     <= 1'b0;
      r_ecc_corrected <= 1'b0;
    end else if (sclr) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_inflight      <= '0;
      r_ecc_fatal     <= 1'b0;
      r_ecc_corrected <= 1'b0;
    end else begin
      r_inflight <= RD_LATENCY'({r_inflight, fifo_rdreq});
      if (w_capture) begin
        r_wr_ptr        <= next_ptr(r_wr_ptr);
        r_ecc_corrected <= fifo_ecc_status[ECC_CORR_BIT];
        if (fifo_ecc_status[ECC_FATAL_BIT]) begin
          r_ecc_fatal <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage is deliberately unreset; o_valid qualifies it.
  always_ff @(posedge clock) begin
    if (w_capture && !sclr && !aclr) begin
      r_buf[r_wr_ptr] <= fifo_q;
    end
  end

  assign o_valid         = (r_count != '0);
  assign o_data          = r_buf[r_rd_ptr];
  assign o_ecc_fatal     = r_ecc_fatal;
  assign o_ecc_corrected = r_ecc_corrected;
  assign o_occupancy     = r_count;

  always @(posedge clock) begin
    if (!aclr) begin
      assert (RD_LATENCY >= 1 && RD_LATENCY <= RD_LATENCY_MAX &&
              BUF_DEPTH > RD_LATENCY && BUF_DEPTH <= 16);
      assert (w_credits <= CRD_W'(BUF_DEPTH));
    end
  end

endmodule
